// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a byte-laned on-chip SRAM. Serves one burst at a time
// (FIXED/INCR) with a programmable gap between the address handshake and the first data beat.
module axi4_sram_slave #(
    parameter logic [31:0] BASE    = 32'h80000000,
    parameter int          MEM_AW  = 12,
    parameter int          LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_slave_awvalid,
    input  logic [31:0] io_slave_awaddr,
    input  logic [3:0]  io_slave_awid,
    input  logic [7:0]  io_slave_awlen,
    input  logic [2:0]  io_slave_awsize,
    input  logic [1:0]  io_slave_awburst,
    output logic        io_slave_awready,
    input  logic        io_slave_wvalid,
    input  logic [31:0] io_slave_wdata,
    input  logic [3:0]  io_slave_wstrb,
    input  logic        io_slave_wlast,
    output logic        io_slave_wready,
    input  logic        io_slave_bready,
    output logic        io_slave_bvalid,
    output logic [1:0]  io_slave_bresp,
    output logic [3:0]  io_slave_bid,
    input  logic        io_slave_arvalid,
    input  logic [31:0] io_slave_araddr,
    input  logic [3:0]  io_slave_arid,
    input  logic [7:0]  io_slave_arlen,
    input  logic [2:0]  io_slave_arsize,
    input  logic [1:0]  io_slave_arburst,
    output logic        io_slave_arready,
    input  logic        io_slave_rready,
    output logic        io_slave_rvalid,
    output logic [1:0]  io_slave_rresp,
    output logic [31:0] io_slave_rdata,
    output logic        io_slave_rlast,
    output logic [3:0]  io_slave_rid
);

    localparam int         DEPTH    = 1 << MEM_AW;
    localparam logic [7:0] LAT_INIT = 8'(LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DATA,
        WR_WAIT,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t      state_reg;
    logic [7:0]  lat_cnt_reg;
    logic [31:0] addr_reg;
    logic [3:0]  id_reg;
    logic [7:0]  len_reg;
    logic [1:0]  burst_reg;
    logic [7:0]  beat_reg;
    logic        rvalid_reg;
    logic        rlast_reg;
    logic [1:0]  rresp_reg;
    logic        rzero_reg;
    logic        wready_reg;
    logic        bvalid_reg;
    logic [1:0]  bresp_reg;
    logic [1:0]  bacc_reg;

    logic              aw_hs;
    logic              ar_hs;
    logic              rd_load;
    logic [31:0]       rd_addr;
    logic [1:0]        rd_burst;
    logic [1:0]        rd_resp;
    logic [31:0]       next_addr;
    logic [1:0]        wr_resp;
    logic              w_hs;
    logic              w_final;
    logic              mem_we;
    logic [1:0]        bacc_next;
    logic [MEM_AW-1:0] rd_idx;
    logic [MEM_AW-1:0] wr_idx;
    logic [31:0]       rd_word;
    logic              unused_ok;

    // Per-beat response: outside the window wins over an unsupported burst type.
    function automatic logic [1:0] beat_resp(input logic [31:0] a, input logic [1:0] b);
        logic [31:0] off_hi;
        off_hi = (a - BASE) >> (MEM_AW + 2);
        if (off_hi != 32'd0) return 2'b11;
        if (b[1]) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [1:0] worse(input logic [1:0] x, input logic [1:0] y);
        return (x > y) ? x : y;
    endfunction

    assign io_slave_awready = (state_reg == IDLE) && !reset;
    assign io_slave_arready = (state_reg == IDLE) && !reset && !io_slave_awvalid;

    assign aw_hs = io_slave_awvalid && io_slave_awready;
    assign ar_hs = io_slave_arvalid && io_slave_arready;

    assign next_addr = (burst_reg == 2'b01) ? addr_reg + 32'd4 : addr_reg;
    assign wr_resp   = beat_resp(addr_reg, burst_reg);
    assign w_hs      = (state_reg == WR_DATA) && wready_reg && io_slave_wvalid;
    assign w_final   = (beat_reg == len_reg);
    assign mem_we    = w_hs && (wr_resp == 2'b00) && !reset;
    assign bacc_next = worse(worse(bacc_reg, wr_resp),
                             (io_slave_wlast != w_final) ? 2'b10 : 2'b00);
    assign wr_idx    = addr_reg[MEM_AW+1:2];
    assign rd_idx    = rd_addr[MEM_AW+1:2];

    // The RAM read is registered, so the word for the next visible beat is fetched
    // in the cycle before it is presented.
    always_comb begin
        rd_load  = 1'b0;
        rd_addr  = addr_reg;
        rd_burst = burst_reg;
        case (state_reg)
            IDLE: begin
                if (ar_hs && LATENCY == 0) begin
                    rd_load  = 1'b1;
                    rd_addr  = io_slave_araddr;
                    rd_burst = io_slave_arburst;
                end
            end
            RD_WAIT: rd_load = (lat_cnt_reg == 8'd1);
            RD_DATA: begin
                if (rvalid_reg && io_slave_rready && !rlast_reg) begin
                    rd_load = 1'b1;
                    rd_addr = next_addr;
                end
            end
            default: rd_load = 1'b0;
        endcase
        rd_resp = beat_resp(rd_addr, rd_burst);
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] ram [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clock) begin
                if (mem_we && io_slave_wstrb[gi])
                    ram[wr_idx] <= io_slave_wdata[gi*8 +: 8];
                if (rd_load)
                    rd_byte_reg <= ram[rd_idx];
            end

            assign rd_word[gi*8 +: 8] = rd_byte_reg;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            lat_cnt_reg <= 8'd0;
            addr_reg    <= 32'd0;
            id_reg      <= 4'd0;
            len_reg     <= 8'd0;
            burst_reg   <= 2'b00;
            beat_reg    <= 8'd0;
            rvalid_reg  <= 1'b0;
            rlast_reg   <= 1'b0;
            rresp_reg   <= 2'b00;
            rzero_reg   <= 1'b1;
            wready_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= 2'b00;
            bacc_reg    <= 2'b00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (aw_hs) begin
                        addr_reg    <= io_slave_awaddr;
                        id_reg      <= io_slave_awid;
                        len_reg     <= io_slave_awlen;
                        burst_reg   <= io_slave_awburst;
                        beat_reg    <= 8'd0;
                        bacc_reg    <= 2'b00;
                        lat_cnt_reg <= LAT_INIT;
                        if (LATENCY == 0) begin
                            state_reg  <= WR_DATA;
                            wready_reg <= 1'b1;
                        end else begin
                            state_reg <= WR_WAIT;
                        end
                    end else if (ar_hs) begin
                        addr_reg    <= io_slave_araddr;
                        id_reg      <= io_slave_arid;
                        len_reg     <= io_slave_arlen;
                        burst_reg   <= io_slave_arburst;
                        beat_reg    <= 8'd0;
                        lat_cnt_reg <= LAT_INIT;
                        if (LATENCY == 0) begin
                            state_reg  <= RD_DATA;
                            rvalid_reg <= 1'b1;
                            rlast_reg  <= (io_slave_arlen == 8'd0);
                            rresp_reg  <= rd_resp;
                            rzero_reg  <= (rd_resp != 2'b00);
                        end else begin
                            state_reg <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt_reg == 8'd1) begin
                        state_reg  <= RD_DATA;
                        rvalid_reg <= 1'b1;
                        rlast_reg  <= (len_reg == 8'd0);
                        rresp_reg  <= rd_resp;
                        rzero_reg  <= (rd_resp != 2'b00);
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 8'd1;
                    end
                end
                RD_DATA: begin
                    if (rvalid_reg && io_slave_rready) begin
                        if (rlast_reg) begin
                            rvalid_reg <= 1'b0;
                            rlast_reg  <= 1'b0;
                            state_reg  <= IDLE;
                        end else begin
                            beat_reg  <= beat_reg + 8'd1;
                            addr_reg  <= next_addr;
                            rlast_reg <= (beat_reg + 8'd1 == len_reg);
                            rresp_reg <= rd_resp;
                            rzero_reg <= (rd_resp != 2'b00);
                        end
                    end
                end
                WR_WAIT: begin
                    if (lat_cnt_reg == 8'd1) begin
                        state_reg  <= WR_DATA;
                        wready_reg <= 1'b1;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 8'd1;
                    end
                end
                WR_DATA: begin
                    if (w_hs) begin
                        bacc_reg <= bacc_next;
                        if (w_final) begin
                            wready_reg <= 1'b0;
                            bvalid_reg <= 1'b1;
                            bresp_reg  <= bacc_next;
                            state_reg  <= WR_RESP;
                        end else begin
                            beat_reg <= beat_reg + 8'd1;
                            addr_reg <= next_addr;
                        end
                    end
                end
                WR_RESP: begin
                    if (io_slave_bready) begin
                        bvalid_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign io_slave_wready = wready_reg;
    assign io_slave_bvalid = bvalid_reg;
    assign io_slave_bresp  = bresp_reg;
    assign io_slave_bid    = id_reg;
    assign io_slave_rvalid = rvalid_reg;
    assign io_slave_rresp  = rresp_reg;
    assign io_slave_rlast  = rlast_reg;
    assign io_slave_rid    = id_reg;
    assign io_slave_rdata  = rzero_reg ? 32'd0 : rd_word;

    // Transfer size is irrelevant: write lanes come from wstrb, reads return whole words.
    assign unused_ok = ^{io_slave_awsize, io_slave_arsize};

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: expectations are queued from a byte-level
// reference memory when stimulus is issued and popped as R/B beats arrive.
module tb_axi4_sram_slave;

    localparam logic [31:0] BASE    = 32'h80000000;
    localparam int          MEM_AW  = 12;
    localparam int          LATENCY = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid, awready, wvalid, wready, wlast, bready, bvalid;
    logic        arvalid, arready, rready, rvalid, rlast;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  awid, arid, wstrb, bid, rid;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;

    always #5 clock = ~clock;

    axi4_sram_slave #(.BASE(BASE), .MEM_AW(MEM_AW), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset),
        .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr), .io_slave_awid(awid),
        .io_slave_awlen(awlen), .io_slave_awsize(awsize), .io_slave_awburst(awburst),
        .io_slave_awready(awready),
        .io_slave_wvalid(wvalid), .io_slave_wdata(wdata), .io_slave_wstrb(wstrb),
        .io_slave_wlast(wlast), .io_slave_wready(wready),
        .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
        .io_slave_bid(bid),
        .io_slave_arvalid(arvalid), .io_slave_araddr(araddr), .io_slave_arid(arid),
        .io_slave_arlen(arlen), .io_slave_arsize(arsize), .io_slave_arburst(arburst),
        .io_slave_arready(arready),
        .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
        .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rexp_t;

    typedef struct packed {
        logic [1:0] resp;
        logic [3:0] id;
    } bexp_t;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_mem [0:4095];
    rexp_t       rq [$];
    bexp_t       bq [$];
    logic [31:0] wb_data [256];
    logic [3:0]  wb_strb [256];
    logic        wb_last [256];

    function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [1:0] b);
        if (a < BASE || a >= BASE + 32'h4000) return 2'b11;
        if (b == 2'b10 || b == 2'b11) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic [1:0] b);
        return (b == 2'b01) ? a + 32'd4 : a;
    endfunction

    task automatic fill(input int i, input logic [31:0] d, input logic [3:0] s, input logic l);
        wb_data[i] = d;
        wb_strb[i] = s;
        wb_last[i] = l;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] b, output bit ok);
        int n;
        n = 0;
        awaddr = a; awid = id; awlen = len; awburst = b; awsize = 3'd2; awvalid = 1'b1;
        #1;
        while (!awready && n < 50) begin @(negedge clock); #1; n++; end
        ok = awready;
        if (!ok) begin
            total++; bad++;
            $display("FAIL aw_handshake: awready=%0b after %0d cycles, need 1", awready, n);
        end else begin
            @(posedge clock);
        end
        @(negedge clock);
        awvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] b, output bit ok);
        int n;
        n = 0;
        araddr = a; arid = id; arlen = len; arburst = b; arsize = 3'd2; arvalid = 1'b1;
        #1;
        while (!arready && n < 50) begin @(negedge clock); #1; n++; end
        ok = arready;
        if (!ok) begin
            total++; bad++;
            $display("FAIL ar_handshake: arready=%0b after %0d cycles, need 1", arready, n);
        end else begin
            @(posedge clock);
        end
        @(negedge clock);
        arvalid = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                            input logic [1:0] b);
        logic [31:0] cur, w;
        logic [1:0]  acc, r;
        bexp_t       e;
        bit          ok;
        int          n;
        cur = a;
        acc = 2'b00;
        aw_send(a, id, len, b, ok);
        if (!ok) return;
        for (int i = 0; i <= int'(len); i++) begin
            wdata = wb_data[i]; wstrb = wb_strb[i]; wlast = wb_last[i]; wvalid = 1'b1;
            n = 0;
            #1;
            while (!wready && n < 50) begin @(negedge clock); #1; n++; end
            if (!wready) begin
                total++; bad++;
                $display("FAIL write_handshake: beat %0d wready=0 after %0d cycles", i, n);
                wvalid = 1'b0;
                return;
            end
            if (i == 0) begin
                total++;
                if (n !== LATENCY) begin
                    bad++;
                    $display("FAIL write_latency: wready after %0d idle cycles, need %0d", n, LATENCY);
                end
            end
            @(posedge clock);
            r = exp_resp(cur, b);
            if (r == 2'b00) begin
                w = model_mem[cur[13:2]];
                for (int j = 0; j < 4; j++)
                    if (wb_strb[i][j]) w[j*8 +: 8] = wb_data[i][j*8 +: 8];
                model_mem[cur[13:2]] = w;
            end
            if (r > acc) acc = r;
            if (wb_last[i] != (i == int'(len)) && acc < 2'b10) acc = 2'b10;
            cur = step(cur, b);
            @(negedge clock);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        e.resp = acc;
        e.id   = id;
        bq.push_back(e);
        total++;
        if (bvalid !== 1'b1) begin
            bad++;
            $display("FAIL b_timing: bvalid=%0b one cycle after last W, need 1", bvalid);
        end
        n = 0;
        while (!bvalid && n < 50) begin @(negedge clock); n++; end
        if (!bvalid) begin
            total++; bad++;
            $display("FAIL b_wait: bvalid=0 after %0d cycles, need 1", n);
            bq.delete();
            return;
        end
        bready = 1'b1;
        e = bq.pop_front();
        total++;
        if ({bresp, bid} !== {e.resp, e.id}) begin
            bad++;
            $display("FAIL write_resp: bresp=%b bid=%0d, need bresp=%b bid=%0d", bresp, bid, e.resp, e.id);
        end
        @(negedge clock);
        bready = 1'b0;
        total++;
        if (bvalid !== 1'b0) begin
            bad++;
            $display("FAIL b_drop: bvalid=%0b after B handshake, need 0", bvalid);
        end
        $display("wr addr=%h id=%0d len=%0d burst=%0d bresp=%b", a, id, len, b, e.resp);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] b, input bit stall);
        logic [31:0] cur, held_data;
        logic [1:0]  held_resp;
        logic        held_last;
        rexp_t       e;
        bit          ok, stalled, rr;
        int          n, k, got, guard;
        cur = a;
        for (int i = 0; i <= int'(len); i++) begin
            e.resp = exp_resp(cur, b);
            e.data = (e.resp == 2'b00) ? model_mem[cur[13:2]] : 32'h0;
            e.last = (i == int'(len));
            e.id   = id;
            rq.push_back(e);
            cur = step(cur, b);
        end
        ar_send(a, id, len, b, ok);
        if (!ok) begin rq.delete(); return; end
        n = 1;
        while (!rvalid && n < 50) begin @(negedge clock); n++; end
        total++;
        if (n !== 1 + LATENCY) begin
            bad++;
            $display("FAIL read_latency: first rvalid at T+%0d, need T+%0d", n, 1 + LATENCY);
        end
        k = 0; got = 0; guard = 0; stalled = 1'b0;
        held_data = '0; held_resp = '0; held_last = 1'b0;
        while (got <= int'(len) && guard < 2000) begin
            if (rvalid) begin
                if (stalled) begin
                    total++;
                    if ({rdata, rresp, rlast} !== {held_data, held_resp, held_last}) begin
                        bad++;
                        $display("FAIL read_hold: beat %0d rdata=%h rresp=%b rlast=%b, need %h %b %b",
                                 got, rdata, rresp, rlast, held_data, held_resp, held_last);
                    end
                end
                rr = stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
                k++;
                rready = rr;
                if (rr) begin
                    e = rq.pop_front();
                    total++;
                    if (rdata !== e.data) begin
                        bad++;
                        $display("FAIL read_data: beat %0d rdata=%h, need %h", got, rdata, e.data);
                    end
                    total++;
                    if ({rresp, rlast, rid} !== {e.resp, e.last, e.id}) begin
                        bad++;
                        $display("FAIL read_ctl: beat %0d rresp=%b rlast=%b rid=%0d, need %b %b %0d",
                                 got, rresp, rlast, rid, e.resp, e.last, e.id);
                    end
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_data = rdata;
                    held_resp = rresp;
                    held_last = rlast;
                end
            end else begin
                rready = 1'b0;
            end
            @(negedge clock);
            guard++;
        end
        rready = 1'b0;
        if (got <= int'(len)) begin
            total++; bad++;
            $display("FAIL read_beats: got %0d beats, need %0d", got, int'(len) + 1);
            rq.delete();
        end else begin
            total++;
            if (rvalid !== 1'b0) begin
                bad++;
                $display("FAIL read_end: rvalid=%0b after last beat, need 0", rvalid);
            end
        end
        $display("rd addr=%h id=%0d len=%0d burst=%0d beats=%0d", a, id, len, b, got);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        @(negedge clock);
        total++;
        if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b0) begin
            bad++;
            $display("FAIL reset_valids: aw/ar/w ready, b/r valid, rlast = %b, need 000000",
                     {awready, arready, wready, bvalid, rvalid, rlast});
        end
        total++;
        if ({rdata, rresp, bresp, rid, bid} !== 44'h0) begin
            bad++;
            $display("FAIL reset_fields: rdata=%h rresp=%b bresp=%b rid=%0d bid=%0d, need all 0",
                     rdata, rresp, bresp, rid, bid);
        end
        reset = 1'b0;
        #1;
        total++;
        if ({awready, arready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_release: awready=%b arready=%b, need 1 1", awready, arready);
        end
        $display("reset released");
    endtask

    task automatic test_single;
        @(negedge clock);
        fill(0, 32'hDEADBEEF, 4'hF, 1'b1);
        do_write(BASE + 32'h10, 4'd5, 8'd0, 2'b01);
        do_read(BASE + 32'h10, 4'd3, 8'd0, 2'b01, 1'b0);
    endtask

    task automatic test_strobe;
        @(negedge clock);
        fill(0, 32'h11223344, 4'hF, 1'b1);
        do_write(BASE + 32'h20, 4'd1, 8'd0, 2'b01);
        fill(0, 32'hAABBCCDD, 4'b0101, 1'b1);
        do_write(BASE + 32'h20, 4'd2, 8'd0, 2'b01);
        do_read(BASE + 32'h20, 4'd4, 8'd0, 2'b01, 1'b0);
    endtask

    task automatic test_incr_stall;
        @(negedge clock);
        for (int i = 0; i < 4; i++) fill(i, 32'(i), 4'hF, (i == 3));
        do_write(BASE, 4'd6, 8'd3, 2'b01);
        do_read(BASE, 4'd7, 8'd3, 2'b01, 1'b1);
    endtask

    task automatic test_fixed;
        @(negedge clock);
        fill(0, 32'h01010101, 4'hF, 1'b0);
        fill(1, 32'h02020202, 4'hF, 1'b1);
        do_write(BASE + 32'h40, 4'd8, 8'd1, 2'b00);
        do_read(BASE + 32'h40, 4'd9, 8'd1, 2'b00, 1'b0);
    endtask

    task automatic test_priority;
        @(negedge clock);
        araddr = BASE + 32'h50; arid = 4'd10; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2;
        arvalid = 1'b1;
        awaddr = BASE + 32'h50; awid = 4'd11; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2;
        awvalid = 1'b1;
        #1;
        total++;
        if ({awready, arready} !== 2'b10) begin
            bad++;
            $display("FAIL priority_ready: awready=%b arready=%b, need 1 0", awready, arready);
        end
        fill(0, 32'hCAFEF00D, 4'hF, 1'b1);
        do_write(BASE + 32'h50, 4'd11, 8'd0, 2'b01);
        do_read(BASE + 32'h50, 4'd10, 8'd0, 2'b01, 1'b0);
    endtask

    task automatic test_errors;
        @(negedge clock);
        do_read(32'h00000000, 4'd1, 8'd0, 2'b01, 1'b0);
        do_read(BASE, 4'd2, 8'd1, 2'b10, 1'b0);
        fill(0, 32'h5A5A5A5A, 4'hF, 1'b0);
        fill(1, 32'hA5A5A5A5, 4'hF, 1'b1);
        do_write(BASE + 32'h3FFC, 4'd3, 8'd1, 2'b01);
        do_read(BASE + 32'h3FFC, 4'd4, 8'd1, 2'b01, 1'b0);
        fill(0, 32'h77777777, 4'hF, 1'b1);
        do_write(32'h00001000, 4'd5, 8'd0, 2'b01);
        fill(0, 32'h31415926, 4'hF, 1'b0);
        do_write(BASE + 32'h30, 4'd6, 8'd0, 2'b01);
        fill(0, 32'h99999999, 4'hF, 1'b1);
        do_write(BASE + 32'h30, 4'd7, 8'd0, 2'b11);
        do_read(BASE + 32'h30, 4'd8, 8'd0, 2'b01, 1'b0);
    endtask

    task automatic test_reset_mid;
        bit ok;
        int n;
        @(negedge clock);
        for (int i = 0; i < 4; i++) fill(i, 32'hA0A0A0A0 + 32'(i), 4'hF, (i == 3));
        do_write(BASE + 32'h100, 4'd12, 8'd3, 2'b01);
        aw_send(BASE + 32'h100, 4'd13, 8'd3, 2'b01, ok);
        if (!ok) return;
        wdata = 32'hB0B0B0B0; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
        n = 0;
        #1;
        while (!wready && n < 50) begin @(negedge clock); #1; n++; end
        if (!wready) begin
            total++; bad++;
            $display("FAIL reset_mid_handshake: wready=0 after %0d cycles", n);
            wvalid = 1'b0;
            return;
        end
        @(posedge clock);
        model_mem[12'h040] = 32'hB0B0B0B0;
        @(negedge clock);
        wdata = 32'hB1B1B1B1;
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({wready, bvalid} !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid_abort: wready=%b bvalid=%b, need 0 0", wready, bvalid);
        end
        wdata = 32'hB2B2B2B2;
        @(negedge clock);
        wdata = 32'hB3B3B3B3;
        @(negedge clock);
        wvalid = 1'b0;
        reset  = 1'b0;
        $display("reset during write burst");
        do_read(BASE + 32'h100, 4'd1, 8'd0, 2'b01, 1'b0);
        do_read(BASE + 32'h108, 4'd2, 8'd1, 2'b01, 1'b0);
    endtask

    initial begin
        awvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0; arsize = '0; arburst = '0;
        rready = 1'b0;
        test_reset;
        test_single;
        test_strobe;
        test_incr_stall;
        test_fixed;
        test_priority;
        test_errors;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/axi4_sram_slave.md
Name: axi4_sram_slave

Overview:
- AXI4 slave (responder) backed by a word-addressed on-chip SRAM array; it is the far end of the core's AXI4 master port.
- Used as the simulation and FPGA memory model the CPU fetches and loads/stores against.
- Serves one transaction at a time, supports FIXED/INCR bursts, byte strobes and a programmable response latency.

Parameters:
BASE, 32'h80000000, base byte address of the memory window
MEM_AW, 12, log2 of depth in 32-bit words (window size = 4<<MEM_AW bytes)
LATENCY, 2, idle cycles between address handshake and first R beat / first wready (0 legal)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
io_slave_awvalid/awaddr/awid/awlen/awsize/awburst  input  1/32/4/8/3/2  write address channel
io_slave_awready  output  1  write address accept
io_slave_wvalid/wdata/wstrb/wlast  input  1/32/4/1  write data channel
io_slave_wready  output  1  write data accept
io_slave_bready  input  1  master ready for response
io_slave_bvalid/bresp/bid  output  1/2/4  write response
io_slave_arvalid/araddr/arid/arlen/arsize/arburst  input  1/32/4/8/3/2  read address channel
io_slave_arready  output  1  read address accept
io_slave_rready  input  1  master ready for data
io_slave_rvalid/rresp/rdata/rlast/rid  output  1/2/32/1/4  read data channel

Behaviour:
- Reset: clock and reset as above; reset is synchronous and active-high. State=IDLE; all valid/ready outputs 0 during reset; rdata, rresp, bresp, rid, bid = 0; rlast = 0. Memory contents are not cleared.
- States: IDLE, RD_WAIT, RD_DATA, WR_WAIT, WR_DATA, WR_RESP.
- IDLE: awready=1; arready = !awvalid. Write has priority when both valids are high in the same cycle.
- Address capture: on AW or AR handshake, latch addr, id, len and burst. Go to RD_WAIT/WR_WAIT with latency counter = LATENCY.
- Latency: for a handshake in cycle T, the first rvalid (or wready) asserts in cycle T+1+LATENCY. LATENCY=0 skips the WAIT state.
- RD_DATA: rvalid=1, rid=latched id, rdata=mem[word index], rlast=1 only when beat count == len.
  - rdata, rresp, rlast are held stable while rvalid && !rready.
  - Each rvalid&&rready advances the beat. After the last beat, return to IDLE next cycle.
- WR_DATA: wready=1. Each wvalid&&wready writes bytes whose wstrb bit is 1.
  - After beat count == awlen is accepted, go to WR_RESP.
  - wlast mismatch (early wlast, or missing wlast on the final beat) does not change the beat count; it forces bresp=2'b10.
- WR_RESP: bvalid=1 starting the cycle after the final W handshake; bid=latched id. Hold until bready, then IDLE next cycle.
- Address update per beat:
  - INCR (2'b01): +4.
  - FIXED (2'b00): unchanged.
  - WRAP (2'b10) or reserved (2'b11): unsupported. Every beat returns SLVERR 2'b10 with rdata=0, and writes are suppressed.
- Word index = addr[MEM_AW+1:2]; addr[1:0] is ignored. awsize/arsize are ignored (lanes come from wstrb; reads always return the full word).
- Range check per beat: addr - BASE >= 4<<MEM_AW gives DECERR 2'b11. For reads, that beat's rdata=0. For writes, that beat is dropped and bresp=2'b11. DECERR overrides SLVERR. Otherwise resp=2'b00.
- Burst length = len+1 beats (1..256). A burst crossing the window end errors only on its out-of-range beats.
- Reset mid-transaction: aborts in the next cycle. No further memory writes occur; words already written keep their values.
- Only one outstanding transaction at a time: awready=arready=0 outside IDLE.

Test Plan:
1. Hold reset 2 cycles, release -> all valid outputs 0 during reset; the first cycle after release has awready=1 and arready=1.
2. AW 0x80000010 len0 id5, W 0xDEADBEEF strb 4'hF wlast=1 -> bvalid one cycle after the W handshake, bresp 00, bid 5. Then AR 0x80000010 id3 -> rvalid at T+3 (LATENCY=2), rdata 0xDEADBEEF, rlast 1, rid 3.
3. Write 0x11223344, then rewrite the same word with 0xAABBCCDD strb 4'b0101 -> a read returns 0x11BB33DD.
4. Write 4 words 0x0..0x3 at 0x80000000, then INCR read len3 with rready toggled 1,0,0,1... -> 4 beats in order 0..3, rdata stable during stalls, rlast only on beat 4.
5. awvalid and arvalid asserted in the same IDLE cycle to the same address -> arready=0 and the write completes first; the read is accepted after the B handshake and returns the new data.
6. Each case independently:
   - AR 0x00000000 -> rresp 11, rdata 0.
   - AR WRAP burst -> rresp 10.
   - Reset asserted during beat 2 of a len3 write -> wready 0 next cycle; beats 3-4 are not written.
